// File: rtl/inst_data_arbiter_pkg.sv
// inst_data_arbiter_pkg: shared state encoding and bus constants for the fetch/data arbiter
package inst_data_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    IF_DROP  = 2'd3
  } state_t;
  localparam logic [3:0] SEL_WORD = 4'hF;
endpackage

// File: rtl/inst_data_arbiter.sv
// inst_data_arbiter: shares one memory bus between instruction fetch and data access with starvation guard
module inst_data_arbiter
  import inst_data_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_ready,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  input  logic              flush,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem
);
  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);
  state_t state;
  logic [SW-1:0] starve_cnt;
  logic idle_ok, if_win, mem_win;
  assign idle_ok      = (state == IDLE) && !if_ready && !mem_ready;
  assign if_win       = idle_ok && if_ce && !flush && (!mem_ce || starve_cnt == S_MAX);
  assign mem_win      = idle_ok && mem_ce && !if_win;
  assign stallreq_if  = if_ce & ~if_ready;
  assign stallreq_mem = mem_ce & ~mem_ready;
  // grant in IDLE, hold the bus until ack, then return the result with a one-cycle ready pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_sel    <= '0;
      bus_wdata  <= '0;
      if_data    <= '0;
      mem_rdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      starve_cnt <= (!if_ce || if_win) ? '0 :
                    (mem_win && starve_cnt != S_MAX) ? starve_cnt + 1'b1 : starve_cnt;
      case (state)
        IDLE: if (if_win || mem_win) begin
          bus_req   <= 1'b1;
          bus_we    <= mem_win && mem_we;
          bus_addr  <= mem_win ? mem_addr : if_addr;
          bus_sel   <= mem_win ? mem_sel : SEL_WORD;
          bus_wdata <= mem_win ? mem_wdata : '0;
          state     <= mem_win ? MEM_BUSY : IF_BUSY;
        end
        IF_BUSY: if (bus_ack) begin
          bus_req <= 1'b0;
          state   <= IDLE;
          if (!flush) begin
            if_data  <= bus_rdata;
            if_ready <= 1'b1;
          end
        end else if (flush) state <= IF_DROP;
        IF_DROP: if (bus_ack) begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
        MEM_BUSY: if (bus_ack) begin
          bus_req   <= 1'b0;
          mem_ready <= 1'b1;
          mem_rdata <= bus_we ? mem_rdata : bus_rdata;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/inst_data_arbiter.md
INST_DATA_ARBITER -- requirements
Module: inst_data_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning bus/request address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning bus/request data width.
REQ-003 SHALL have parameter STARVE_MAX, default 2, meaning consecutive data grants allowed while a fetch waits.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low (rst==0 resets).
REQ-006 SHALL have port if_ce  input  1  instruction fetch request, held until if_ready.
REQ-007 SHALL have port if_addr  input  ADDR_W  fetch address (pc).
REQ-008 SHALL have port if_data  output  DATA_W  fetched instruction, registered.
REQ-009 SHALL have port if_ready  output  1  one-cycle pulse: if_data valid; drives pc_read_ready.
REQ-010 SHALL have port mem_ce  input  1  data access request, held until mem_ready.
REQ-011 SHALL have port mem_we  input  1  1 = write, 0 = read.
REQ-012 SHALL have port mem_addr  input  ADDR_W  data address.
REQ-013 SHALL have port mem_sel  input  4  byte enables.
REQ-014 SHALL have port mem_wdata  input  DATA_W  write data.
REQ-015 SHALL have port mem_rdata  output  DATA_W  read data, registered.
REQ-016 SHALL have port mem_ready  output  1  one-cycle pulse: access complete.
REQ-017 SHALL have port flush  input  1  pipeline flush from CTRL.
REQ-018 SHALL have ports bus_req/bus_we/bus_addr/bus_sel/bus_wdata  output  1/1/ADDR_W/4/DATA_W  shared memory bus, all registered.
REQ-019 SHALL have ports bus_ack/bus_rdata  input  1/DATA_W  slave completion, read data valid with ack.
REQ-020 SHALL have ports stallreq_if/stallreq_mem  output  1/1  stall requests to CTRL.

Function
- FSM states IDLE, IF_BUSY, MEM_BUSY, IF_DROP.
REQ-021 SHALL, in IDLE with any request, latch the winner's address/we/sel/wdata into bus_* and assert bus_req from the next cycle.
REQ-022 SHALL grant mem over if, except when starve_cnt==STARVE_MAX and if_ce==1, then grant if.
REQ-023 SHALL increment starve_cnt (saturating) on each mem grant while if_ce==1, clear it on any if grant or when if_ce==0.
REQ-024 SHALL hold bus_* stable while bus_req==1 until bus_ack==1.
REQ-025 SHALL, on bus_ack in IF_BUSY, register bus_rdata into if_data, pulse if_ready next cycle, deassert bus_req, return to IDLE.
REQ-026 SHALL, on bus_ack in MEM_BUSY, register bus_rdata into mem_rdata (unchanged on write), pulse mem_ready, return to IDLE.
REQ-027 SHALL, on flush in IF_BUSY without same-cycle ack, enter IF_DROP; on ack in IF_DROP return to IDLE with no if_ready pulse.
REQ-028 SHALL treat flush coincident with ack in IF_BUSY as drop (no if_ready).
REQ-029 SHALL not abort or drop MEM_BUSY on flush; flush in IDLE suppresses that cycle's if grant only.
REQ-030 SHALL return to IDLE for at least one cycle between transactions (minimum 3 cycles request-to-ready with 1-cycle ack).
REQ-031 SHALL drive stallreq_if = if_ce & ~if_ready and stallreq_mem = mem_ce & ~mem_ready combinationally.

Reset
REQ-032 SHALL, when rst==0 at a clock edge, enter IDLE, clear starve_cnt, bus_req, bus_we, if_ready, mem_ready, and zero bus_addr/bus_sel/bus_wdata/if_data/mem_rdata.
REQ-033 SHALL abandon any in-flight transaction on reset without a ready pulse.

Structure
REQ-034 SHALL take bus widths, Ready/ChipEnable encodings and ZeroWord from the shared defines.v; FSM state encodings SHALL be localparams.
REQ-035 SHALL be a single module with no sub-modules.

Verification
REQ-036 SHALL cover: if_ce, addr 0xbfc00000, ack 1 cycle after bus_req, rdata 0x24010001 -> if_ready pulse at cycle 3, if_data 0x24010001.
REQ-037 SHALL cover: if_ce and mem_ce (write 0x80000010, sel 0xF) same cycle -> mem granted first, bus_we=1, then fetch; stallreq_if high throughout.
REQ-038 SHALL cover: mem_ce held for 4 back-to-back accesses with if_ce pending -> third grant goes to if (STARVE_MAX=2).
REQ-039 SHALL cover: flush during IF_BUSY, ack 3 cycles later -> no if_ready, bus_req drops after ack, next fetch uses new address.
REQ-040 SHALL cover: rst=0 mid MEM_BUSY -> next cycle IDLE, bus_req=0, no mem_ready.
